// File: rtl/mem_access_pkg.sv
// Shared constants for the MEM-stage data memory initiator:
// funct3 encodings, FSM states and fault cause codes.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // size code is funct3[1:0]: 0=B 1=H 2=W 3=D
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [2:0] off
    );
        logic m;
        unique case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            2'b10:   m = |off[1:0];
            default: m = |off;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 64-bit doubleword and the
// addressed sub-word: store merge and load extract/extend.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [63:0] old_dw_i,
    input  logic [63:0] wdata_i,
    input  logic [2:0]  st_off_i,
    input  logic [1:0]  st_size_i,
    output logic [63:0] new_dw_o,
    input  logic [63:0] ld_dw_i,
    input  logic [2:0]  ld_off_i,
    input  logic [2:0]  ld_funct3_i,
    output logic [63:0] ld_data_o
);

    logic [5:0]  st_sh;
    logic [5:0]  ld_sh;
    logic [63:0] mask;
    logic [63:0] mask_sh;
    logic [63:0] ld_sdw;

    assign st_sh = {st_off_i, 3'b000};
    assign ld_sh = {ld_off_i, 3'b000};

    always_comb begin
        mask = '1;
        unique case (st_size_i)
            2'b00:   mask = 64'h0000_0000_0000_00ff;
            2'b01:   mask = 64'h0000_0000_0000_ffff;
            2'b10:   mask = 64'h0000_0000_ffff_ffff;
            default: mask = '1;
        endcase
    end

    assign mask_sh  = mask << st_sh;
    assign new_dw_o = (old_dw_i & ~mask_sh)
                    | ((wdata_i << st_sh) & mask_sh);

    // little-endian: lane at offset k moves down to bit 0
    assign ld_sdw = ld_dw_i >> ld_sh;

    always_comb begin
        ld_data_o = ld_sdw;
        unique case (ld_funct3_i)
            F3_B:  ld_data_o = {{56{ld_sdw[7]}}, ld_sdw[7:0]};
            F3_H:  ld_data_o = {{48{ld_sdw[15]}}, ld_sdw[15:0]};
            F3_W:  ld_data_o = {{32{ld_sdw[31]}}, ld_sdw[31:0]};
            F3_BU: ld_data_o = {56'h0, ld_sdw[7:0]};
            F3_HU: ld_data_o = {48'h0, ld_sdw[15:0]};
            F3_WU: ld_data_o = {32'h0, ld_sdw[31:0]};
            default: ld_data_o = ld_sdw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: one load/store at a time, doubleword
// memory cycles, read-modify-write for narrow stores, faults.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic [63:0] address,
    output logic [63:0] writeData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] readData
);

    state_e      state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic [63:0] address_q;
    logic [63:0] wr_data_q;
    logic        mem_write_q;
    logic        mem_read_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [1:0]  resp_cause_q;
    logic [63:0] resp_rdata_q;

    logic        illegal;
    logic        misal;
    logic        out_of_range;
    logic [1:0]  cause_d;
    logic [63:0] merged_dw;
    logic [63:0] load_val;

    always_comb begin
        if (req_is_store) begin
            illegal = req_funct3[2];
        end else begin
            illegal = (req_funct3 == 3'b111);
        end
        misal = misaligned(req_funct3[1:0], req_addr[2:0]);
        out_of_range = (req_addr >= 64'(MEM_SIZE_BYTES));
        cause_d = CAUSE_NONE;
        // terms are made exclusive so the priority is explicit
        unique case (1'b1)
            illegal:
                cause_d = CAUSE_ILLEGAL;
            !illegal && misal:
                cause_d = CAUSE_MISALIGN;
            !illegal && !misal && out_of_range:
                cause_d = CAUSE_RANGE;
            default:
                cause_d = CAUSE_NONE;
        endcase
    end

    mem_lane_align u_align (
        .old_dw_i    (readData),
        .wdata_i     (wdata_q),
        .st_off_i    (off_q),
        .st_size_i   (funct3_q[1:0]),
        .new_dw_o    (merged_dw),
        .ld_dw_i     (readData),
        .ld_off_i    (off_q),
        .ld_funct3_i (funct3_q),
        .ld_data_o   (load_val)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 3'b000;
            wdata_q      <= 64'h0;
            address_q    <= 64'h0;
            wr_data_q    <= 64'h0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
            resp_rdata_q <= 64'h0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_store_q   <= req_is_store;
                        funct3_q     <= req_funct3;
                        off_q        <= req_addr[2:0];
                        wdata_q      <= req_wdata;
                        address_q    <= {req_addr[63:3], 3'b000};
                        resp_rdata_q <= 64'h0;
                        if (cause_d != CAUSE_NONE) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_cause_q <= cause_d;
                        end else if (req_is_store
                                     && req_funct3 == F3_D) begin
                            state_q     <= ST_WRITE;
                            mem_write_q <= 1'b1;
                            wr_data_q   <= req_wdata;
                        end else begin
                            state_q    <= ST_READ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_read_q <= 1'b0;
                    if (is_store_q) begin
                        state_q     <= ST_WRITE;
                        mem_write_q <= 1'b1;
                        wr_data_q   <= merged_dw;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_val;
                    end
                end
                ST_WRITE: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_cause_q <= CAUSE_NONE;
                    resp_rdata_q <= 64'h0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign resp_cause = resp_cause_q;
    assign address    = address_q;
    assign writeData  = wr_data_q;
    assign MemWrite   = mem_write_q;
    assign MemRead    = mem_read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-level memory
// model and a per-cycle compare against expected timing/data.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_cause;
    logic [63:0] address;
    logic [63:0] writeData;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] readData;

    mem_access_unit #(.MEM_SIZE_BYTES(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .resp_cause   (resp_cause),
        .address      (address),
        .writeData    (writeData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .readData     (readData)
    );

    always #5 clk = ~clk;

    // DataMemory stand-in
    logic [63:0] dmem [128];
    assign readData = MemRead ? dmem[address[9:3]] : 64'h0;
    always @(posedge clk) begin
        if (MemWrite) dmem[address[9:3]] <= writeData;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference byte memory and expectations
    logic [7:0]  ref_mem [1024];
    int          acc = -10;
    int          busy_end = -10;
    int          exp_rd = -1;
    int          exp_wr = -1;
    int          exp_resp = -1;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    logic [63:0] exp_rdata;
    logic [63:0] exp_wdata;
    logic [63:0] exp_addr;
    bit          chk_en = 0;
    logic [63:0] last_rd;
    logic [63:0] last_wd;
    logic [1:0]  last_cause;
    logic        last_fault;

    task automatic model_req(input logic st,
                             input logic [2:0] f3,
                             input logic [63:0] a,
                             input logic [63:0] wd,
                             input bit commit);
        int n;
        int ai;
        int base;
        logic [63:0] v;
        n = 1 << f3[1:0];
        exp_fault = 0;
        exp_cause = 2'd0;
        exp_rdata = 64'h0;
        exp_rd = -1;
        exp_wr = -1;
        exp_addr = {a[63:3], 3'b000};
        if (st ? (f3 >= 3'd4) : (f3 == 3'd7)) exp_cause = 2'd3;
        else if (a % 64'(n) != 0) exp_cause = 2'd1;
        else if (a >= 64'd1024) exp_cause = 2'd2;
        if (exp_cause != 2'd0) begin
            exp_fault = 1;
            exp_resp = acc + 1;
        end else if (!st) begin
            ai = int'(a);
            v = 64'h0;
            for (int i = 0; i < n; i++)
                v |= 64'(ref_mem[ai + i]) << (8 * i);
            if (f3 < 3'd3 && v[8 * n - 1])
                for (int i = n; i < 8; i++)
                    v |= 64'hff << (8 * i);
            exp_rdata = v;
            exp_rd = acc + 1;
            exp_resp = acc + 2;
        end else begin
            ai = int'(a);
            if (n == 8) begin
                exp_wr = acc + 1;
                exp_resp = acc + 2;
            end else begin
                exp_rd = acc + 1;
                exp_wr = acc + 2;
                exp_resp = acc + 3;
            end
            if (commit)
                for (int i = 0; i < n; i++)
                    ref_mem[ai + i] = wd[8 * i +: 8];
            base = ai & ~7;
            exp_wdata = 64'h0;
            for (int i = 0; i < 8; i++)
                exp_wdata |= 64'(ref_mem[base + i]) << (8 * i);
        end
        busy_end = exp_resp;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(req_ready),
                64'(!(cyc > acc && cyc <= busy_end)));
            chk("MemRead", 64'(MemRead), 64'(cyc == exp_rd));
            chk("MemWrite", 64'(MemWrite), 64'(cyc == exp_wr));
            chk("resp_valid", 64'(resp_valid), 64'(cyc == exp_resp));
            if (cyc == exp_rd) chk("rd_address", address, exp_addr);
            if (cyc == exp_wr) begin
                chk("wr_address", address, exp_addr);
                chk("writeData", writeData, exp_wdata);
                last_wd = writeData;
            end
            if (cyc == exp_resp) begin
                chk("resp_fault", 64'(resp_fault), 64'(exp_fault));
                chk("resp_cause", 64'(resp_cause), 64'(exp_cause));
                chk("resp_rdata", resp_rdata, exp_rdata);
                last_rd = resp_rdata;
                last_fault = resp_fault;
                last_cause = resp_cause;
            end
        end
    end

    task automatic scramble();
        req_is_store = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic issue(input logic st,
                         input logic [2:0] f3,
                         input logic [63:0] a,
                         input logic [63:0] wd);
        @(negedge clk);
        acc = cyc;
        model_req(st, f3, a, wd, 1);
        req_is_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        scramble();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cyc >= busy_end) break;
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) dmem[i] = 64'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 64'h0;
        req_wdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_memread", 64'(MemRead), 64'd0);
        chk("rst_memwrite", 64'(MemWrite), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_address", address, 64'h0);
        chk("rst_writedata", writeData, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_cause", 64'(resp_cause), 64'd0);
        reset = 1'b1;
        chk_en = 1;

        issue(1, 3'b011, 64'h08, 64'hDEADBEEFDEADBEEF);
        chk("sd_wd", last_wd, 64'hDEADBEEFDEADBEEF);
        issue(0, 3'b011, 64'h08, 64'h0);
        chk("ld_08", last_rd, 64'hDEADBEEFDEADBEEF);
        issue(0, 3'b000, 64'h0F, 64'h0);
        chk("model_lb", exp_rdata, 64'hFFFFFFFFFFFFFFDE);
        chk("lb_0f", last_rd, 64'hFFFFFFFFFFFFFFDE);
        issue(0, 3'b100, 64'h0F, 64'h0);
        chk("lbu_0f", last_rd, 64'h00000000000000DE);
        issue(0, 3'b010, 64'h0C, 64'h0);
        chk("lw_0c", last_rd, 64'hFFFFFFFFDEADBEEF);
        issue(0, 3'b110, 64'h0C, 64'h0);
        chk("lwu_0c", last_rd, 64'h00000000DEADBEEF);
        issue(1, 3'b001, 64'h0A, 64'h1234);
        chk("model_sh", exp_wdata, 64'hDEADBEEF1234BEEF);
        chk("sh_wd", last_wd, 64'hDEADBEEF1234BEEF);
        issue(0, 3'b011, 64'h08, 64'h0);
        chk("ld_after_sh", last_rd, 64'hDEADBEEF1234BEEF);

        issue(0, 3'b010, 64'h0A, 64'h0);
        chk("lw_mis_cause", 64'(last_cause), 64'd1);
        chk("lw_mis_fault", 64'(last_fault), 64'd1);
        issue(0, 3'b011, 64'h400, 64'h0);
        chk("ld_range", 64'(last_cause), 64'd2);
        issue(1, 3'b100, 64'h10, 64'h55);
        chk("st_illegal", 64'(last_cause), 64'd3);
        issue(0, 3'b111, 64'h10, 64'h0);
        chk("ld_illegal", 64'(last_cause), 64'd3);
        issue(0, 3'b011, 64'h401, 64'h0);
        chk("mis_over_range", 64'(last_cause), 64'd1);
        issue(1, 3'b101, 64'h400, 64'h0);
        chk("ill_over_range", 64'(last_cause), 64'd3);
        issue(1, 3'b011, 64'h3FC, 64'h0);
        chk("sd_mis_3fc", 64'(last_cause), 64'd1);

        issue(1, 3'b010, 64'h100, 64'h0000000080000001);
        issue(0, 3'b010, 64'h100, 64'h0);
        chk("lw_100", last_rd, 64'hFFFFFFFF80000001);
        issue(0, 3'b101, 64'h102, 64'h0);
        chk("lhu_102", last_rd, 64'h0000000000008000);
        issue(0, 3'b001, 64'h102, 64'h0);
        chk("lh_102", last_rd, 64'hFFFFFFFFFFFF8000);
        issue(1, 3'b000, 64'h3FF, 64'hFFFF_FFFF_FFFF_FFA5);
        issue(0, 3'b100, 64'h3FF, 64'h0);
        chk("lbu_3ff", last_rd, 64'h00000000000000A5);
        issue(0, 3'b011, 64'h3F8, 64'h0);
        chk("ld_3f8", last_rd, 64'hA500000000000000);

        // reset lands on the closing edge of an SB read cycle
        @(negedge clk);
        acc = cyc;
        model_req(1, 3'b000, 64'h09, 64'h77, 0);
        exp_wr = -1;
        exp_resp = -1;
        busy_end = acc + 1;
        req_is_store = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 64'h09;
        req_wdata = 64'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        issue(0, 3'b011, 64'h08, 64'h0);
        chk("ld_after_rst", last_rd, 64'hDEADBEEF1234BEEF);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
